mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Two-requester arbiter and sequencer in front of memory_controller. It shares the single memory_controller/inst_rom path between the core (port 0: fetch and load/store) and a boot/debug loader (port 1: SPI image loader or debug write-back). It registers one transaction at a time, drives the memory_controller strobes, and returns read data with a one-cycle done pulse. A read timeout guards against a hung memory.

Parameters:
ADDR_W, 64, address width on requester and memory sides
DATA_W, 64, data width
TIMEOUT, 255, maximum cycles in READ before mc_read_done; range 1..65535

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
m0_req  in  1  core request, level
m0_we  in  1  1 = write, 0 = read
m0_addr  in  ADDR_W  core address
m0_wdata  in  DATA_W  core write data
m0_size  in  2  access size (0 = byte, 1 = half, 2 = word, 3 = double)
m0_unsigned  in  1  zero-extend load
m0_gnt  out  1  one-cycle pulse: transaction accepted
m0_done  out  1  one-cycle pulse: transaction complete
m0_rdata  out  DATA_W  read data, valid when m0_done = 1
m1_req, m1_we, m1_addr, m1_wdata, m1_size, m1_unsigned, m1_gnt, m1_done, m1_rdata: same as the m0_* ports, for the loader
mc_re  out  1  read strobe to memory_controller
mc_we  out  1  write strobe to memory_controller
mc_addr  out  ADDR_W  registered address
mc_wdata  out  DATA_W  registered write data
mc_size  out  2  registered size
mc_unsigned  out  1  registered unsigned flag
mc_rdata  in  DATA_W  memory_controller core_data_out
mc_read_done  in  1  memory_controller mem_read_done
timeout_err  out  1  one-cycle pulse, coincident with done on a timed-out read

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - state = IDLE, last_grant = 1 (core wins the first tie), timeout counter = 0.
  - All outputs 0, including rdata and the mc_* registers.
- Reset asserted mid-transaction aborts it. Strobes drop at that same edge. No done pulse is issued.
- All outputs are registered.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - If any req is high, pick the owner. Single requester: that port wins. Both requesting: the port != last_grant wins (round-robin).
  - Latch the owner's command into the mc_* registers.
  - Next state is READ if we = 0, otherwise WRITE.
  - Owner's gnt = 1 during the first READ/WRITE cycle only.
- READ:
  - mc_re = 1 every cycle.
  - Counter increments each cycle.
  - If mc_read_done = 1: capture mc_rdata into owner rdata, go to RESP.
  - Else if counter == TIMEOUT - 1: set owner rdata = 0, flag timeout, go to RESP.
  - mc_read_done together with the limit in the same cycle: the data wins and no timeout is flagged.
- WRITE: mc_we = 1 for exactly one cycle, then go to RESP.
- RESP:
  - Owner done = 1. timeout_err = 1 if the timeout was flagged.
  - mc_re = mc_we = 0.
  - last_grant = owner; counter cleared.
  - Go to IDLE.
- Latency:
  - Request sampled in cycle 0 → gnt and strobe in cycle 1.
  - Write: done in cycle 2.
  - Read with mc_read_done in cycle 1 + k: done in cycle 2 + k.
  - Back-to-back: the next grant is no earlier than 2 cycles after done.
- Requester rules:
  - Hold req and command stable until gnt.
  - Drop req by the edge after done unless a further transaction is wanted.
  - Command inputs are ignored outside IDLE.
- The non-owner's gnt, done and rdata are unchanged while the other port is served. rdata holds its last value.
- mc_read_done outside READ is ignored.
- At most one done pulse is issued per grant. gnt and done never coincide.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding localparams (IDLE/READ/WRITE/RESP)
  - port IDs (PORT_CORE = 0, PORT_LOAD = 1)
  - access-size constants, shared with memory_controller and main_decoder
- One sub-module, rr_pick2: combinational two-way round-robin pick from {req0, req1, last_grant} producing {valid, owner}. It is reused later for the interrupt acknowledge path.

Test Plan:
- Core read only: m0_req = 1, addr 0x40, mc_read_done after 3 cycles with mc_rdata = 0xDEADBEEF_00000013 → m0_gnt in cycle 1, mc_re cycles 1–4, m0_done in cycle 5 with m0_rdata = 0xDEADBEEF_00000013; m1_* stay 0.
- Loader write: m1_req = 1, we = 1, addr 0x100, wdata 0x1122334455667788, size 3 → mc_we exactly 1 cycle with mc_addr = 0x100, m1_done in cycle 2.
- Simultaneous requests after reset: both req held over 4 transactions → grant order core, loader, core, loader; no port starved.
- Timeout: TIMEOUT = 8, core read, mc_read_done never asserts → mc_re high 8 cycles, then m0_done and timeout_err together, m0_rdata = 0; a following request is served normally.
- Data/timeout tie: mc_read_done asserted in the limit cycle → done with data, timeout_err = 0.
- Reset mid-read: reset_n = 0 during READ → at the next edge all outputs 0, no done pulse; after release the core wins the first tie.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory-port arbiter and its neighbours.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, requester port IDs, access-size codes
// (common with memory_controller and main_decoder), the timeout counter
// width and a small command-control struct used on the select path.
package mem_arb_pkg;

   // Sequencer states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Requester port IDs
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LOAD = 1'b1;

   // Access sizes
   localparam logic [1:0] SIZE_BYTE  = 2'd0;
   localparam logic [1:0] SIZE_HALF  = 2'd1;
   localparam logic [1:0] SIZE_WORD  = 2'd2;
   localparam logic [1:0] SIZE_DWORD = 2'd3;

   // Wide enough for the largest supported TIMEOUT (65535)
   localparam int TMO_CNT_W = 16;

   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       uns;
   } cmd_ctl_t;

   // First busy state for a freshly granted command
   function automatic logic [1:0] first_busy_state(input logic we);
      return we ? ST_WRITE : ST_READ;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: chooses one of two level requests.
// Latency: combinational, zero cycles.
// Backpressure: none; caller decides when the pick is consumed.
//
// Ports:
//   i_req0, i_req1  request levels of port 0 / port 1
//   i_last_grant    port that was served most recently
//   o_valid         at least one request present
//   o_owner         selected port (only meaningful when o_valid = 1)
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last_grant,
   output logic o_valid,
   output logic o_owner
);

   assign o_valid = i_req0 | i_req1;

   always_comb begin
      o_owner = PORT_CORE;
      if (i_req0 && i_req1) begin
         // Tie: the port that did not win last time goes next
         o_owner = ~i_last_grant;
      end else if (i_req1) begin
         o_owner = PORT_LOAD;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates core (port 0) and loader (port 1) onto the single memory_controller path.
// Latency: gnt+strobe 1 cycle after request; write done at cycle 2, read done 1 cycle after mc_read_done.
// Backpressure: one transaction in flight; a requester holds req/command until its gnt pulse.
//
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   m0_* / m1_*                requester ports (req level, command, gnt/done pulses, rdata)
//   mc_re, mc_we, mc_addr,     registered strobes and command toward memory_controller
//   mc_wdata, mc_size, mc_unsigned
//   mc_rdata, mc_read_done     read data and completion from memory_controller
//   timeout_err                pulse alongside done when a read gave up waiting
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [1:0]        m0_size,
   input  logic              m0_unsigned,
   output logic              m0_gnt,
   output logic              m0_done,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [1:0]        m1_size,
   input  logic              m1_unsigned,
   output logic              m1_gnt,
   output logic              m1_done,
   output logic [DATA_W-1:0] m1_rdata,

   output logic              mc_re,
   output logic              mc_we,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [DATA_W-1:0] mc_wdata,
   output logic [1:0]        mc_size,
   output logic              mc_unsigned,
   input  logic [DATA_W-1:0] mc_rdata,
   input  logic              mc_read_done,
   output logic              timeout_err
);

   // Counter value seen in the last READ cycle the memory is allowed
   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

   logic [1:0]           r_state;
   logic                 r_owner;
   logic                 r_last_grant;
   logic [TMO_CNT_W-1:0] r_cnt;
   logic [1:0]           r_gnt;
   logic [1:0]           r_done;
   logic [DATA_W-1:0]    r_rdata0;
   logic [DATA_W-1:0]    r_rdata1;
   logic                 r_mc_re;
   logic                 r_mc_we;
   logic [ADDR_W-1:0]    r_mc_addr;
   logic [DATA_W-1:0]    r_mc_wdata;
   logic [1:0]           r_mc_size;
   logic                 r_mc_unsigned;
   logic                 r_timeout_err;

   logic                 w_pick_vld;
   logic                 w_pick_owner;
   logic [ADDR_W-1:0]    w_sel_addr;
   logic [DATA_W-1:0]    w_sel_wdata;
   cmd_ctl_t             w_sel_ctl;
   logic                 w_tmo_hit;

   rr_pick2 u_pick (
      .i_req0       (m0_req),
      .i_req1       (m1_req),
      .i_last_grant (r_last_grant),
      .o_valid      (w_pick_vld),
      .o_owner      (w_pick_owner)
   );

   // Command of whichever port the picker selected
   always_comb begin
      w_sel_addr     = m0_addr;
      w_sel_wdata    = m0_wdata;
      w_sel_ctl.we   = m0_we;
      w_sel_ctl.size = m0_size;
      w_sel_ctl.uns  = m0_unsigned;
      if (w_pick_owner == PORT_LOAD) begin
         w_sel_addr     = m1_addr;
         w_sel_wdata    = m1_wdata;
         w_sel_ctl.we   = m1_we;
         w_sel_ctl.size = m1_size;
         w_sel_ctl.uns  = m1_unsigned;
      end
   end

   assign w_tmo_hit = (r_cnt == TMO_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_owner       <= PORT_CORE;
         r_last_grant  <= PORT_LOAD;   // so the core wins the first tie
         r_cnt         <= '0;
         r_gnt         <= '0;
         r_done        <= '0;
         r_rdata0      <= '0;
         r_rdata1      <= '0;
         r_mc_re       <= 1'b0;
         r_mc_we       <= 1'b0;
         r_mc_addr     <= '0;
         r_mc_wdata    <= '0;
         r_mc_size     <= '0;
         r_mc_unsigned <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         // Pulse outputs default low; each state raises them for one cycle
         r_gnt         <= '0;
         r_done        <= '0;
         r_timeout_err <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_pick_vld) begin
                  r_owner             <= w_pick_owner;
                  r_mc_addr           <= w_sel_addr;
                  r_mc_wdata          <= w_sel_wdata;
                  r_mc_size           <= w_sel_ctl.size;
                  r_mc_unsigned       <= w_sel_ctl.uns;
                  r_mc_re             <= ~w_sel_ctl.we;
                  r_mc_we             <= w_sel_ctl.we;
                  r_cnt               <= '0;
                  r_gnt[w_pick_owner] <= 1'b1;
                  r_state             <= first_busy_state(w_sel_ctl.we);
               end
            end

            ST_READ: begin
               r_cnt <= r_cnt + 1'b1;
               // Data arriving in the limit cycle takes priority over the timeout
               if (mc_read_done) begin
                  if (r_owner == PORT_LOAD) begin
                     r_rdata1 <= mc_rdata;
                  end else begin
                     r_rdata0 <= mc_rdata;
                  end
                  r_mc_re        <= 1'b0;
                  r_done[r_owner] <= 1'b1;
                  r_state        <= ST_RESP;
               end else if (w_tmo_hit) begin
                  if (r_owner == PORT_LOAD) begin
                     r_rdata1 <= '0;
                  end else begin
                     r_rdata0 <= '0;
                  end
                  r_mc_re         <= 1'b0;
                  r_done[r_owner] <= 1'b1;
                  r_timeout_err   <= 1'b1;
                  r_state         <= ST_RESP;
               end
            end

            ST_WRITE: begin
               r_mc_we         <= 1'b0;
               r_done[r_owner] <= 1'b1;
               r_state         <= ST_RESP;
            end

            ST_RESP: begin
               r_last_grant <= r_owner;
               r_cnt        <= '0;
               r_state      <= ST_IDLE;
            end

            default: begin
               r_mc_re <= 1'b0;
               r_mc_we <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign m0_gnt      = r_gnt[PORT_CORE];
   assign m1_gnt      = r_gnt[PORT_LOAD];
   assign m0_done     = r_done[PORT_CORE];
   assign m1_done     = r_done[PORT_LOAD];
   assign m0_rdata    = r_rdata0;
   assign m1_rdata    = r_rdata1;
   assign mc_re       = r_mc_re;
   assign mc_we       = r_mc_we;
   assign mc_addr     = r_mc_addr;
   assign mc_wdata    = r_mc_wdata;
   assign mc_size     = r_mc_size;
   assign mc_unsigned = r_mc_unsigned;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then randomized traffic.
// Expected grant port, done cycle, rdata and timeout come from a transaction-level model.
// Memory side is a bench responder returning data after a per-command latency.
module tb_mem_port_arbiter;

   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          m0_req, m0_we, m0_unsigned, m0_gnt, m0_done;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic [1:0]    m0_size;
   logic          m1_req, m1_we, m1_unsigned, m1_gnt, m1_done;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [1:0]    m1_size;
   logic          mc_re, mc_we, mc_unsigned, mc_read_done, timeout_err;
   logic [AW-1:0] mc_addr;
   logic [DW-1:0] mc_wdata, mc_rdata;
   logic [1:0]    mc_size;

   int n_chk  = 0;
   int n_fail = 0;

   // Requester model: pending command per port
   bit          pend[2];
   bit          p_we[2];
   logic [63:0] p_addr[2];
   logic [63:0] p_wdata[2];
   logic [63:0] p_data[2];
   logic [1:0]  p_size[2];
   bit          p_uns[2];
   int          p_lat[2];
   int          last_g;
   logic [63:0] exp_rd[2];

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_size(m0_size), .m0_unsigned(m0_unsigned), .m0_gnt(m0_gnt), .m0_done(m0_done),
      .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_size(m1_size), .m1_unsigned(m1_unsigned), .m1_gnt(m1_gnt), .m1_done(m1_done),
      .m1_rdata(m1_rdata),
      .mc_re(mc_re), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
      .mc_size(mc_size), .mc_unsigned(mc_unsigned), .mc_rdata(mc_rdata),
      .mc_read_done(mc_read_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic set_cmd(input int p, input bit we, input logic [63:0] a, input logic [63:0] w,
                          input logic [63:0] d, input logic [1:0] sz, input bit u, input int lat);
      pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = w;
      p_data[p] = d; p_size[p] = sz; p_uns[p] = u; p_lat[p] = lat;
   endtask

   task automatic rand_cmd(input int p);
      set_cmd(p, 1'($urandom_range(0, 1)), rnd64(), rnd64(), rnd64(),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 11)));
   endtask

   task automatic drive_ports();
      m0_req = pend[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
      m0_size = p_size[0]; m0_unsigned = p_uns[0];
      m1_req = pend[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
      m1_size = p_size[1]; m1_unsigned = p_uns[1];
   endtask

   // Owner's command lines change while it is being served; req stays high
   task automatic scramble(input int p);
      if (p == 0) begin
         m0_we = 1'($urandom_range(0, 1)); m0_addr = rnd64(); m0_wdata = rnd64();
         m0_size = 2'($urandom_range(0, 3)); m0_unsigned = 1'($urandom_range(0, 1));
      end else begin
         m1_we = 1'($urandom_range(0, 1)); m1_addr = rnd64(); m1_wdata = rnd64();
         m1_size = 2'($urandom_range(0, 3)); m1_unsigned = 1'($urandom_range(0, 1));
      end
   endtask

   // Memory noise: read_done outside a read must be ignored
   task automatic drive_mem_rand();
      mc_read_done = 1'($urandom_range(0, 1));
      mc_rdata     = rnd64();
   endtask

   // Inputs for busy cycle c (c = 1 is the grant cycle)
   task automatic drive_mem(input int c, input bit we, input int k, input logic [63:0] d);
      if (!we) begin
         mc_read_done = (c == 1 + k);
         mc_rdata     = (c == 1 + k) ? d : rnd64();
      end else begin
         drive_mem_rand();
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk(tag, 64'({m0_gnt, m0_done, m1_gnt, m1_done, mc_re, mc_we, mc_unsigned, timeout_err}), 64'd0);
      chk({tag, "_data"}, m0_rdata | m1_rdata | mc_addr | mc_wdata | 64'(mc_size), 64'd0);
   endtask

   task automatic model_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      last_g = 1;
      exp_rd[0] = '0; exp_rd[1] = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      drive_ports();
      drive_mem_rand();
      @(negedge clk);
      @(negedge clk);
      check_all_zero("rst_outs");
      reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("idle_pulses", 64'({m0_gnt, m1_gnt, m0_done, m1_done, timeout_err}), 64'd0);
         drive_mem_rand();
      end
   endtask

   // One transaction from request to done; returns at the negedge of the done cycle
   task automatic do_txn(input int gap);
      int owner, other, waited, k, d;
      bit we, to;
      logic [1:0] g;
      owner  = (pend[0] && pend[1]) ? 1 - last_g : (pend[0] ? 0 : 1);
      other  = 1 - owner;
      drive_ports();
      waited = 0;
      g      = '0;
      while (g == 2'b00 && waited < 20) begin
         @(negedge clk);
         waited++;
         g = {m1_gnt, m0_gnt};
         if (g == 2'b00) begin
            chk("no_extra_done", 64'({m1_done, m0_done}), 64'd0);
            drive_mem_rand();
         end
      end
      chk("gnt_gap", 64'(waited), 64'(gap));
      if (g == 2'b00) return;
      chk("gnt_port", 64'(g), (owner == 0) ? 64'd1 : 64'd2);
      we = p_we[owner];
      chk("mc_strobes", 64'({mc_we, mc_re}), 64'({we, !we}));
      chk("mc_addr", mc_addr, p_addr[owner]);
      chk("mc_wdata", mc_wdata, p_wdata[owner]);
      chk("mc_size_uns", 64'({mc_size, mc_unsigned}), 64'({p_size[owner], p_uns[owner]}));
      k  = we ? 0 : p_lat[owner];
      to = !we && (k > TMO - 1);
      d  = we ? 2 : 2 + ((k > TMO - 1) ? TMO - 1 : k);
      pend[owner] = 1'b0;
      scramble(owner);
      drive_mem(1, we, k, p_data[owner]);
      for (int c = 2; c <= d; c++) begin
         @(negedge clk);
         if (c < d) begin
            chk("busy_pulses", 64'({m0_gnt, m1_gnt, m0_done, m1_done, timeout_err}), 64'd0);
            chk("busy_strobe", 64'({mc_we, mc_re}), 64'd1);
            drive_mem(c, we, k, p_data[owner]);
         end else begin
            chk("done_port", 64'({m1_done, m0_done}), (owner == 0) ? 64'd1 : 64'd2);
            chk("gnt_at_done", 64'({m1_gnt, m0_gnt}), 64'd0);
            if (!we) exp_rd[owner] = to ? 64'd0 : p_data[owner];
            chk("rdata_owner", (owner == 0) ? m0_rdata : m1_rdata, exp_rd[owner]);
            chk("rdata_other", (other == 0) ? m0_rdata : m1_rdata, exp_rd[other]);
            chk("timeout_err", 64'(timeout_err), 64'(to));
            chk("strobes_off", 64'({mc_we, mc_re}), 64'd0);
            drive_mem_rand();
         end
      end
      last_g = owner;
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0; p_data[p] = '0;
         p_size[p] = '0; p_uns[p] = 1'b0; p_lat[p] = 0;
      end
      do_reset();

      // Core read, data after 3 cycles
      set_cmd(0, 1'b0, 64'h40, 64'h0, 64'hDEADBEEF_00000013, 2'd3, 1'b0, 3);
      do_txn(1);
      drive_ports();
      idle(1);

      // Loader double-word write
      set_cmd(1, 1'b1, 64'h100, 64'h1122334455667788, 64'h0, 2'd3, 1'b0, 0);
      do_txn(1);
      drive_ports();
      idle(1);

      // Core read that never completes, then a normal loader read
      set_cmd(0, 1'b0, 64'h2000, 64'h0, 64'hAAAA_5555_AAAA_5555, 2'd2, 1'b1, 100);
      do_txn(1);
      set_cmd(1, 1'b0, 64'h3000, 64'h0, 64'h0123_4567_89AB_CDEF, 2'd1, 1'b0, 2);
      drive_ports();
      do_txn(2);

      // Data arrives exactly in the limit cycle
      set_cmd(0, 1'b0, 64'h48, 64'h0, 64'hCAFE_F00D_1234_5678, 2'd3, 1'b0, TMO - 1);
      drive_ports();
      do_txn(2);
      drive_ports();
      idle(1);

      // Reset in the middle of a read
      set_cmd(0, 1'b0, 64'h80, 64'h0, 64'h0, 2'd3, 1'b0, 100);
      drive_ports();
      mc_read_done = 1'b0;
      @(negedge clk);
      chk("midrst_gnt", 64'({m1_gnt, m0_gnt}), 64'd1);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      drive_ports();
      @(negedge clk);
      check_all_zero("midrst_outs");
      reset_n = 1'b1;
      idle(3);

      // Both ports requesting continuously: core first, then alternation
      set_cmd(0, 1'b0, 64'h500, 64'h0, 64'h1111_2222_3333_4444, 2'd3, 1'b0, 1);
      set_cmd(1, 1'b1, 64'h600, 64'h9999_8888_7777_6666, 64'h0, 2'd3, 1'b0, 0);
      do_txn(1);
      for (int i = 0; i < 3; i++) begin
         rand_cmd(last_g);
         do_txn(2);
      end

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && $urandom_range(0, 1) == 1) rand_cmd(p);
         end
         if (!pend[0] && !pend[1]) rand_cmd(int'($urandom_range(0, 1)));
         do_txn(2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
